// File: rtl/warp_fetch_scheduler_pkg.sv
// Shared definitions for the warp fetch scheduler.
// Contents: FSM state encoding, default sizing (warp count, PC width, warp-id width).
package warp_fetch_scheduler_pkg;

  localparam int unsigned NUM_WARPS_DEF = 4;
  localparam int unsigned PC_WIDTH_DEF  = 8;
  localparam int unsigned WID_WIDTH_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } wfs_state_t;

endpackage

// File: rtl/warp_fetch_scheduler_if.sv
// Fetch-side bus between the scheduler and the instruction fetch/decoder.
// master (scheduler): drives fetch_valid, fetch_warp, pc, global_pc; samples issue_ready.
// slave  (decoder)  : samples the fetch request; drives issue_ready.
interface warp_fetch_scheduler_if
  import warp_fetch_scheduler_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = PC_WIDTH_DEF,
  parameter int unsigned WID_WIDTH = WID_WIDTH_DEF
);
  logic                 fetch_valid;
  logic                 issue_ready;
  logic [WID_WIDTH-1:0] fetch_warp;
  logic [PC_WIDTH-1:0]  pc;
  logic [PC_WIDTH-1:0]  global_pc;

  modport master (
    output fetch_valid,
    output fetch_warp,
    output pc,
    output global_pc,
    input  issue_ready
  );

  modport slave (
    input  fetch_valid,
    input  fetch_warp,
    input  pc,
    input  global_pc,
    output issue_ready
  );
endinterface

// File: rtl/warp_fetch_scheduler_picker.sv
// Round-robin priority selector for warp fetch.
// Ports: req (eligible warp mask), ptr (round-robin start position),
//        grant_id (first requester at or after ptr, wrapping), grant_valid.
module rr_warp_picker
  import warp_fetch_scheduler_pkg::*;
#(
  parameter int unsigned NUM_WARPS = NUM_WARPS_DEF,
  parameter int unsigned WID_WIDTH = WID_WIDTH_DEF
) (
  input  logic [NUM_WARPS-1:0] req,
  input  logic [WID_WIDTH-1:0] ptr,
  output logic [WID_WIDTH-1:0] grant_id,
  output logic                 grant_valid
);

  // Two passes: first the slots at/above ptr, then the wrap-around from slot 0.
  always_comb begin
    grant_id    = '0;
    grant_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      if (!grant_valid && req[i] && (i >= 32'(ptr))) begin
        grant_valid = 1'b1;
        grant_id    = WID_WIDTH'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      if (!grant_valid && req[i]) begin
        grant_valid = 1'b1;
        grant_id    = WID_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/warp_fetch_scheduler.sv
// Warp fetch scheduler: holds one PC per warp, picks an eligible warp round-robin
// each free output slot and presents its PC to instruction fetch; also runs a
// global PC stream.
// Ports: clk, rst (sync, active-high); start/launch_mask/start_pc (kernel launch);
//        stall_mask (per-warp hold); branch_valid/branch_warp/branch_target (redirect);
//        halt_valid/halt_warp (retire); global_step (advance global_pc);
//        busy (in RUN), done (one-cycle completion pulse);
//        fetch (master bus: fetch_valid, fetch_warp, pc, global_pc, issue_ready).
module warp_fetch_scheduler
  import warp_fetch_scheduler_pkg::*;
#(
  parameter int unsigned NUM_WARPS = NUM_WARPS_DEF,
  parameter int unsigned PC_WIDTH  = PC_WIDTH_DEF,
  parameter int unsigned WID_WIDTH = WID_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_WARPS-1:0] launch_mask,
  input  logic [PC_WIDTH-1:0]  start_pc,
  input  logic [NUM_WARPS-1:0] stall_mask,
  input  logic                 branch_valid,
  input  logic [WID_WIDTH-1:0] branch_warp,
  input  logic [PC_WIDTH-1:0]  branch_target,
  input  logic                 halt_valid,
  input  logic [WID_WIDTH-1:0] halt_warp,
  input  logic                 global_step,
  output logic                 busy,
  output logic                 done,
  warp_fetch_scheduler_if.master fetch
);

  wfs_state_t           state_q, state_d;
  logic [PC_WIDTH-1:0]  warp_pc_q [NUM_WARPS];
  logic [PC_WIDTH-1:0]  warp_pc_d [NUM_WARPS];
  logic [NUM_WARPS-1:0] active_q, active_d;
  logic [WID_WIDTH-1:0] rr_q;
  logic                 fv_q;
  logic [WID_WIDTH-1:0] fw_q;
  logic [PC_WIDTH-1:0]  pc_q;
  logic [PC_WIDTH-1:0]  gpc_q;

  logic                 run;
  logic                 accept;
  logic                 slot_free;
  logic                 halt_drop;
  logic [NUM_WARPS-1:0] eligible;
  logic [WID_WIDTH-1:0] win_id;
  logic                 win_valid;
  logic [WID_WIDTH-1:0] rr_next;

  assign fetch.fetch_valid = fv_q;
  assign fetch.fetch_warp  = fw_q;
  assign fetch.pc          = pc_q;
  assign fetch.global_pc   = gpc_q;

  assign run       = (state_q == ST_RUN);
  assign accept    = fv_q & fetch.issue_ready;
  assign slot_free = ~fv_q | fetch.issue_ready;
  assign halt_drop = halt_valid & active_q[halt_warp] & (halt_warp == fw_q);

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if ((active_q == '0) && !fv_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // warp_pc_d already carries this cycle's increment/branch, so a warp that is
  // accepted and immediately wins again is presented with its updated PC.
  // Branch is applied after the increment so it takes priority.
  always_comb begin
    warp_pc_d = warp_pc_q;
    active_d  = active_q;
    if (run) begin
      if (accept) warp_pc_d[fw_q] = pc_q + PC_WIDTH'(1);
      if (branch_valid && active_q[branch_warp]) warp_pc_d[branch_warp] = branch_target;
      if (halt_valid && active_q[halt_warp]) active_d[halt_warp] = 1'b0;
    end
  end

  // A warp halted this cycle is no longer a candidate.
  assign eligible = active_d & ~stall_mask;

  rr_warp_picker #(
    .NUM_WARPS (NUM_WARPS),
    .WID_WIDTH (WID_WIDTH)
  ) u_picker (
    .req         (eligible),
    .ptr         (rr_q),
    .grant_id    (win_id),
    .grant_valid (win_valid)
  );

  assign rr_next = (win_id == WID_WIDTH'(NUM_WARPS - 1)) ? '0 : win_id + WID_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      active_q <= '0;
      rr_q     <= '0;
      fv_q     <= 1'b0;
      fw_q     <= '0;
      pc_q     <= '0;
      gpc_q    <= '0;
      for (int unsigned i = 0; i < NUM_WARPS; i++) warp_pc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          fv_q <= 1'b0;
          if (start) begin
            for (int unsigned i = 0; i < NUM_WARPS; i++) warp_pc_q[i] <= start_pc;
            gpc_q    <= start_pc;
            active_q <= launch_mask;
            rr_q     <= '0;
          end
        end
        ST_RUN: begin
          warp_pc_q <= warp_pc_d;
          active_q  <= active_d;
          if (global_step) gpc_q <= gpc_q + PC_WIDTH'(1);
          if (slot_free) begin
            if (win_valid) begin
              fv_q <= 1'b1;
              fw_q <= win_id;
              pc_q <= warp_pc_d[win_id];
              rr_q <= rr_next;
            end else begin
              fv_q <= 1'b0;
            end
          end else if (halt_drop) begin
            fv_q <= 1'b0;
          end
        end
        default: fv_q <= 1'b0;
      endcase
    end
  end

endmodule
